// File: rtl/mips_mc_ctrl_if.sv
// Control/status bundle between the multicycle MIPS controller (master) and its datapath/memory (slave).
interface mips_mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       pc_we;
  logic       ir_we;
  logic       reg_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [3:0] alu_ctrl;
  logic [1:0] fault;

  modport master (
    input  opcode, funct, zero, mem_ack,
    output mem_req, mem_we, iord, pc_we, ir_we, reg_we, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, pc_src, alu_ctrl, fault
  );

  modport slave (
    output opcode, funct, zero, mem_ack,
    input  mem_req, mem_we, iord, pc_we, ir_we, reg_we, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, pc_src, alu_ctrl, fault
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM (Moore); 3-5 cycles per instruction with zero-wait memory.
// Memory states stall until mem_ack and fault after MEM_TIMEOUT silent cycles; FAULT is left only by reset.
module mips_mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  mips_mc_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC_R, S_ALU_WB, S_EXEC_I, S_BRANCH, S_JUMP, S_FAULT
  } state_e;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_XOR = 4'd13;

  localparam logic [1:0] F_NONE   = 2'd0;
  localparam logic [1:0] F_OPCODE = 2'd1;
  localparam logic [1:0] F_FUNCT  = 2'd2;
  localparam logic [1:0] F_TMO    = 2'd3;

  localparam logic [9:0] TMO_LAST = 10'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [1:0] fault_q, fault_d;
  logic [3:0] alu_q, alu_d;
  logic       wb_rd_q, wb_rd_d;

  logic       funct_ok;
  logic [3:0] funct_alu;
  logic       mem_wait;
  state_e     mem_done;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (bus.funct)
      6'h20:   funct_alu = ALU_ADD;
      6'h22:   funct_alu = ALU_SUB;
      6'h24:   funct_alu = ALU_AND;
      6'h25:   funct_alu = ALU_OR;
      6'h27:   funct_alu = ALU_NOR;
      6'h26:   funct_alu = ALU_XOR;
      6'h2A:   funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign mem_done = (state_q == S_FETCH)  ? S_DECODE :
                    (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      fault_q <= F_NONE;
      alu_q   <= ALU_ADD;
      wb_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      alu_q   <= alu_d;
      wb_rd_q <= wb_rd_d;
    end
  end

  // The wait counter only survives while a memory state stalls; any transition clears it.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    fault_d = fault_q;
    alu_d   = alu_q;
    wb_rd_d = wb_rd_q;
    if (mem_wait) begin
      if (bus.mem_ack) begin
        state_d = mem_done;
      end else if (cnt_q == TMO_LAST) begin
        state_d = S_FAULT;
        fault_d = F_TMO;
      end else begin
        cnt_d = cnt_q + 10'd1;
      end
    end else begin
      case (state_q)
        S_DECODE: begin
          case (bus.opcode)
            6'h23, 6'h2B: state_d = S_MEM_ADDR;
            6'h00:        state_d = S_EXEC_R;
            6'h08:        state_d = S_EXEC_I;
            6'h04, 6'h05: state_d = S_BRANCH;
            6'h02:        state_d = S_JUMP;
            default: begin
              state_d = S_FAULT;
              fault_d = F_OPCODE;
            end
          endcase
        end
        S_MEM_ADDR: state_d = (bus.opcode == 6'h2B) ? S_MEM_WR : S_MEM_RD;
        S_EXEC_R: begin
          if (funct_ok) begin
            state_d = S_ALU_WB;
            alu_d   = funct_alu;
            wb_rd_d = 1'b1;
          end else begin
            state_d = S_FAULT;
            fault_d = F_FUNCT;
          end
        end
        S_EXEC_I: begin
          state_d = S_ALU_WB;
          alu_d   = ALU_ADD;
          wb_rd_d = 1'b0;
        end
        S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
        S_FAULT:  state_d = S_FAULT;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.iord       = 1'b0;
    bus.pc_we      = 1'b0;
    bus.ir_we      = 1'b0;
    bus.reg_we     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'd0;
    bus.pc_src     = 2'd0;
    bus.alu_ctrl   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = 2'd1;
        bus.pc_we     = bus.mem_ack;
        bus.ir_we     = bus.mem_ack;
      end
      S_DECODE:   bus.alu_src_b = 2'd3;
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'd2;
      end
      S_MEM_RD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
      end
      S_MEM_WB: begin
        bus.reg_we     = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.iord    = 1'b1;
      end
      S_EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_ctrl  = funct_ok ? funct_alu : ALU_ADD;
      end
      S_ALU_WB: begin
        bus.reg_we   = 1'b1;
        bus.reg_dst  = wb_rd_q;
        bus.alu_ctrl = alu_q;
      end
      S_EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'd2;
      end
      // opcode[0] distinguishes BNE from BEQ, inverting the taken sense of zero.
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_ctrl  = ALU_SUB;
        bus.pc_src    = 2'd1;
        bus.pc_we     = bus.zero ^ bus.opcode[0];
      end
      S_JUMP: begin
        bus.pc_src = 2'd2;
        bus.pc_we  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.fault = fault_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: per-instruction expected traces built from the ISA rules, checked every cycle.
module tb_mips_mc_ctrl;
  localparam int TMO = 4;

  typedef struct packed {
    logic       mem_req, mem_we, iord, pc_we, ir_we, reg_we, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [3:0] alu_ctrl;
    logic [1:0] fault;
  } out_t;

  typedef struct {
    logic ack;
    logic zero;
    out_t exp;
  } step_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  mips_mc_ctrl_if bus();

  mips_mc_ctrl #(.MEM_TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  step_t q[$];
  out_t  obs[$];
  int    checks = 0;
  int    errors = 0;

  function automatic out_t idle();
    out_t o;
    o = '0;
    o.alu_ctrl = 4'd2;
    return o;
  endfunction

  function automatic int alu_of(logic [5:0] fn);
    case (fn)
      6'h20: return 2;
      6'h22: return 6;
      6'h24: return 0;
      6'h25: return 1;
      6'h27: return 12;
      6'h26: return 13;
      6'h2A: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.mem_req = bus.mem_req;     o.mem_we = bus.mem_we;   o.iord = bus.iord;
    o.pc_we = bus.pc_we;         o.ir_we = bus.ir_we;     o.reg_we = bus.reg_we;
    o.reg_dst = bus.reg_dst;     o.mem_to_reg = bus.mem_to_reg;
    o.alu_src_a = bus.alu_src_a; o.alu_src_b = bus.alu_src_b;
    o.pc_src = bus.pc_src;       o.alu_ctrl = bus.alu_ctrl; o.fault = bus.fault;
    return o;
  endfunction

  task automatic push(input logic ack, input logic z, input out_t e);
    step_t s;
    s.ack = ack; s.zero = z; s.exp = e;
    q.push_back(s);
  endtask

  // FAULT ignores acks, so the hold cycles deliberately present mem_ack=1.
  task automatic push_fault(input logic [1:0] code, input int n);
    out_t o;
    o = idle();
    o.fault = code;
    for (int i = 0; i < n; i++) push(1'b1, 1'b0, o);
  endtask

  // kind: 0 = instruction fetch, 1 = data read, 2 = data write; w = cycles before the ack.
  task automatic model_mem(input int kind, input int w, input int nf, output bit faulted);
    out_t o;
    o = idle();
    o.mem_req = 1'b1;
    if (kind == 0) o.alu_src_b = 2'd1;
    else o.iord = 1'b1;
    if (kind == 2) o.mem_we = 1'b1;
    for (int i = 0; i < w && i < TMO; i++) push(1'b0, 1'b0, o);
    if (w >= TMO) begin
      push_fault(2'd3, nf);
      faulted = 1'b1;
    end else begin
      if (kind == 0) begin
        o.pc_we = 1'b1;
        o.ir_we = 1'b1;
      end
      push(1'b1, 1'b0, o);
      faulted = 1'b0;
    end
  endtask

  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw, input int nf, input logic stray);
    out_t o;
    bit   f;
    int   a;
    model_mem(0, fw, nf, f);
    if (f) return;
    o = idle(); o.alu_src_b = 2'd3;
    push(stray, z, o);
    case (op)
      6'h23, 6'h2B: begin
        o = idle(); o.alu_src_a = 1'b1; o.alu_src_b = 2'd2;
        push(1'b0, z, o);
        model_mem((op == 6'h23) ? 1 : 2, mw, nf, f);
        if (!f && op == 6'h23) begin
          o = idle(); o.reg_we = 1'b1; o.mem_to_reg = 1'b1;
          push(1'b0, z, o);
        end
      end
      6'h00: begin
        a = alu_of(fn);
        o = idle(); o.alu_src_a = 1'b1;
        if (a >= 0) o.alu_ctrl = 4'(a);
        push(1'b0, z, o);
        if (a < 0) push_fault(2'd2, nf);
        else begin
          o = idle(); o.reg_we = 1'b1; o.reg_dst = 1'b1; o.alu_ctrl = 4'(a);
          push(1'b0, z, o);
        end
      end
      6'h08: begin
        o = idle(); o.alu_src_a = 1'b1; o.alu_src_b = 2'd2;
        push(1'b0, z, o);
        o = idle(); o.reg_we = 1'b1;
        push(1'b0, z, o);
      end
      6'h04, 6'h05: begin
        o = idle(); o.alu_src_a = 1'b1; o.alu_ctrl = 4'd6; o.pc_src = 2'd1;
        o.pc_we = (op == 6'h04) ? z : !z;
        push(1'b0, z, o);
      end
      6'h02: begin
        o = idle(); o.pc_src = 2'd2; o.pc_we = 1'b1;
        push(1'b0, z, o);
      end
      default: push_fault(2'd1, nf);
    endcase
  endtask

  // Called at posedge+1; leaves time at posedge+1 after the last step.
  task automatic run(input string name);
    step_t s;
    out_t  got;
    int    idx;
    obs.delete();
    idx = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      bus.mem_ack = s.ack;
      bus.zero    = s.zero;
      @(negedge clk);
      got = dut_out();
      obs.push_back(got);
      checks++;
      if (got !== s.exp) begin
        errors++;
        $display("FAIL %s step %0d: got %h expected %h", name, idx, got, s.exp);
      end
      idx++;
      @(posedge clk);
      #1;
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.mem_ack = 1'b0;
    #2;
    chk("rst_mem_req", int'(bus.mem_req), 1);
    chk("rst_iord", int'(bus.iord), 0);
    chk("rst_alu_src_b", int'(bus.alu_src_b), 1);
    chk("rst_alu_ctrl", int'(bus.alu_ctrl), 2);
    chk("rst_fault", int'(bus.fault), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic go(input string name, input logic [5:0] op, input logic [5:0] fn, input logic z,
                    input int fw, input int mw, input int nf, input logic stray);
    bus.opcode = op;
    bus.funct  = fn;
    model_instr(op, fn, z, fw, mw, nf, stray);
    run(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.opcode = 6'h00; bus.funct = 6'h20; bus.zero = 1'b0; bus.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    go("r_sub", 6'h00, 6'h22, 1'b0, 0, 0, 0, 1'b0);
    chk("r_sub_len", obs.size(), 4);
    chk("r_sub_alu", int'(obs[2].alu_ctrl), 6);
    chk("r_sub_wb_reg_we", int'(obs[3].reg_we), 1);
    chk("r_sub_wb_reg_dst", int'(obs[3].reg_dst), 1);
    chk("r_sub_wb_alu_hold", int'(obs[3].alu_ctrl), 6);

    begin
      logic [5:0] fns [6];
      fns = '{6'h20, 6'h24, 6'h25, 6'h27, 6'h26, 6'h2A};
      foreach (fns[i]) go("r_funct", 6'h00, fns[i], 1'b0, i % 3, 0, 0, 1'b1);
    end

    go("lw_late", 6'h23, 6'h00, 1'b0, 0, 3, 0, 1'b0);
    for (int i = 3; i <= 6; i++) begin
      chk("lw_rd_req", int'(obs[i].mem_req), 1);
      chk("lw_rd_iord", int'(obs[i].iord), 1);
    end
    chk("lw_wb_mem_to_reg", int'(obs[7].mem_to_reg), 1);

    go("lw_fast", 6'h23, 6'h00, 1'b0, 0, 0, 0, 1'b0);
    chk("lw_cpi", obs.size(), 5);
    go("sw_fast", 6'h2B, 6'h00, 1'b0, 0, 0, 0, 1'b0);
    chk("sw_cpi", obs.size(), 4);
    go("sw_wait", 6'h2B, 6'h00, 1'b0, 2, 1, 0, 1'b1);
    go("addi", 6'h08, 6'h00, 1'b0, 0, 0, 0, 1'b0);
    chk("addi_wb_reg_dst", int'(obs[3].reg_dst), 0);

    go("bne_z1", 6'h05, 6'h00, 1'b1, 0, 0, 0, 1'b0);
    chk("bne_z1_pc_we", int'(obs[2].pc_we), 0);
    go("bne_z0", 6'h05, 6'h00, 1'b0, 0, 0, 0, 1'b0);
    chk("bne_z0_pc_we", int'(obs[2].pc_we), 1);
    chk("bne_z0_pc_src", int'(obs[2].pc_src), 1);
    go("beq_z1", 6'h04, 6'h00, 1'b1, 0, 0, 0, 1'b0);
    go("beq_z0", 6'h04, 6'h00, 1'b0, 0, 0, 0, 1'b0);
    go("jump", 6'h02, 6'h00, 1'b0, 0, 0, 0, 1'b1);
    chk("jump_cpi", obs.size(), 3);

    // Ack lands in the very cycle the counter hits the limit.
    go("fetch_ack_edge", 6'h02, 6'h00, 1'b0, TMO - 1, 0, 0, 1'b0);
    chk("edge_ir_we", int'(obs[3].ir_we), 1);
    chk("edge_decode_b", int'(obs[4].alu_src_b), 3);
    chk("edge_no_fault", int'(obs[4].fault), 0);

    bus.opcode = 6'h2B;
    begin
      bit f;
      out_t o;
      model_mem(0, 0, 0, f);
      o = idle(); o.alu_src_b = 2'd3; push(1'b0, 1'b0, o);
      o = idle(); o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; push(1'b0, 1'b0, o);
      o = idle(); o.mem_req = 1'b1; o.mem_we = 1'b1; o.iord = 1'b1; push(1'b0, 1'b0, o);
    end
    run("sw_pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    chk("midwr_mem_we", int'(bus.mem_we), 0);
    chk("midwr_mem_req", int'(bus.mem_req), 1);
    chk("midwr_iord", int'(bus.iord), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    go("fetch_timeout", 6'h02, 6'h00, 1'b0, TMO, 0, 3, 1'b0);
    chk("tmo_last_wait_req", int'(obs[TMO-1].mem_req), 1);
    chk("tmo_fault", int'(obs[TMO].fault), 3);
    chk("tmo_req_drop", int'(obs[TMO].mem_req), 0);
    do_reset();

    go("illegal_op", 6'h3F, 6'h00, 1'b0, 0, 0, 10, 1'b0);
    chk("ill_op_fault", int'(obs[2].fault), 1);
    chk("ill_op_req_held", int'(obs[11].mem_req), 0);
    do_reset();

    go("illegal_funct", 6'h00, 6'h3F, 1'b0, 0, 0, 5, 1'b0);
    chk("ill_fn_fault", int'(obs[3].fault), 2);
    do_reset();

    go("rd_timeout", 6'h23, 6'h00, 1'b0, 1, TMO + 2, 4, 1'b0);
    do_reset();
    go("after_reset", 6'h08, 6'h00, 1'b0, 0, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: the maximum number of cycles to wait for mem_ack in any memory state before faulting; legal range 1..1023.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port opcode, input, 6 bits: instruction[31:26], valid from the DECODE state onward.
REQ-005 SHALL have port funct, input, 6 bits: instruction[5:0], used only for R-type.
REQ-006 SHALL have port zero, input, 1 bit: the ALU zero flag, sampled in the BRANCH state.
REQ-007 SHALL have port mem_ack, input, 1 bit: memory completion strobe.
REQ-008 SHALL have port mem_req, output, 1 bit: memory access request.
REQ-009 SHALL have port mem_we, output, 1 bit: marks the memory access as a write.
REQ-010 SHALL have port iord, output, 1 bit: memory address select, 0=PC, 1=ALUOut.
REQ-011 SHALL have ports pc_we and ir_we, outputs, 1 bit each: PC write enable and IR write enable.
REQ-012 SHALL have ports reg_we, reg_dst and mem_to_reg, outputs, 1 bit each: register write enable, write-register select (1=rd, 0=rt) and write-data select (1=MDR).
REQ-013 SHALL have ports alu_src_a (1 bit), alu_src_b (2 bits) and pc_src (2 bits), outputs: ALU A select (0=PC, 1=rs); ALU B select (0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2); PC source select (0=ALU result, 1=ALUOut, 2=jump target).
REQ-014 SHALL have port alu_ctrl, output, 4 bits: ALU control using the codes ADD=2, SUB=6, AND=0, OR=1, NOR=12, SLT=7, XOR=13.
REQ-015 SHALL have port fault, output, 2 bits: 0=none, 1=illegal opcode, 2=illegal funct, 3=memory timeout.

Function
REQ-016 SHALL implement a Moore FSM with the states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, ALU_WB, EXEC_I, BRANCH, JUMP and FAULT.
REQ-017 SHALL, in FETCH, drive mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_ctrl=ADD and pc_src=0; ir_we and pc_we SHALL equal mem_ack, and mem_ack=1 SHALL move the FSM to DECODE.
REQ-018 SHALL, in DECODE, drive alu_src_a=0, alu_src_b=3 and alu_ctrl=ADD, then branch on opcode:
- 0x23 or 0x2B -> MEM_ADDR
- 0x00 -> EXEC_R
- 0x08 -> EXEC_I
- 0x04 or 0x05 -> BRANCH
- 0x02 -> JUMP
- any other opcode -> FAULT with fault=1
REQ-019 SHALL, in MEM_ADDR, drive alu_src_a=1, alu_src_b=2 and alu_ctrl=ADD, then go to MEM_RD for opcode 0x23 or MEM_WR for opcode 0x2B.
REQ-020 SHALL, in MEM_RD, drive mem_req=1 and iord=1, and go to MEM_WB on mem_ack; MEM_WB SHALL drive reg_we=1, reg_dst=0 and mem_to_reg=1, then go to FETCH.
REQ-021 SHALL, in MEM_WR, drive mem_req=1, mem_we=1 and iord=1, and go to FETCH on mem_ack.
REQ-022 SHALL, in EXEC_R, drive alu_src_a=1, alu_src_b=0 and alu_ctrl from funct:
- 0x20 -> ADD; 0x22 -> SUB; 0x24 -> AND
- 0x25 -> OR; 0x27 -> NOR; 0x26 -> XOR; 0x2A -> SLT
- any other funct -> FAULT with fault=2
REQ-023 SHALL, in ALU_WB, drive reg_we=1, reg_dst=1 and mem_to_reg=0, and SHALL hold the alu_ctrl value from EXEC_R.
REQ-024 SHALL, in EXEC_I, drive alu_src_a=1, alu_src_b=2 and alu_ctrl=ADD, then go to ALU_WB with reg_dst=0.
REQ-025 SHALL, in BRANCH, drive alu_src_a=1, alu_src_b=0, alu_ctrl=SUB and pc_src=1, with pc_we=(zero XOR opcode[0]), so BEQ is taken on zero=1 and BNE on zero=0; the FSM SHALL then go to FETCH.
REQ-026 SHALL, in JUMP, drive pc_src=2 and pc_we=1, then go to FETCH.
REQ-027 SHALL hold every output not listed for a state at 0, except alu_ctrl, which defaults to ADD.
REQ-028 SHALL restart a wait counter at 0 on entry to FETCH, MEM_RD or MEM_WR and increment it each cycle mem_ack=0; on reaching MEM_TIMEOUT without an ack, the FSM SHALL go to FAULT with fault=3 and drop mem_req the next cycle.
REQ-029 SHALL give mem_ack priority when it arrives in the same cycle the counter reaches MEM_TIMEOUT, so the access completes with no fault.
REQ-030 SHALL ignore mem_ack outside FETCH, MEM_RD and MEM_WR.
REQ-031 SHALL make FAULT absorbing: all enables 0, fault held, exit only by reset.
REQ-032 SHALL, with zero-wait memory, take these cycles per instruction: LW 5, SW 4, R-type 4, ADDI 4, BEQ/BNE 3, J 3.

Reset
REQ-033 SHALL, on rst_n=0, immediately force state=FETCH, the wait counter to 0, fault=0 and the registered alu_ctrl to ADD, with all outputs at their FETCH Moore values and mem_req=1 once rst_n=1, including when reset hits mid-access.

Verification
REQ-034 SHALL test opcode 0x00 with funct 0x22 and zero-wait ack -> FETCH, DECODE, EXEC_R (alu_ctrl=6), ALU_WB (reg_we=1, reg_dst=1), FETCH; 4 cycles.
REQ-035 SHALL test opcode 0x23 with the ack 3 cycles late in MEM_RD -> mem_req=1, iord=1 held 4 cycles, then MEM_WB with mem_to_reg=1.
REQ-036 SHALL test opcode 0x05 with zero=1 -> pc_we=0 in BRANCH, and with zero=0 -> pc_we=1 and pc_src=1.
REQ-037 SHALL test opcode 0x3F -> FAULT with fault=1 and mem_req=0 held for 10 cycles, then fault=0 with FETCH after reset.
REQ-038 SHALL test MEM_TIMEOUT=4 with no ack in FETCH -> fault=3 after 4 cycles, and an ack on cycle 4 -> DECODE with no fault.
REQ-039 SHALL test rst_n pulsed low during MEM_WR -> mem_we=0 immediately, with state FETCH and the counter at 0 on release.
